imem_loader: RTL and testbench

Program loader that writes instruction memory, the write-side counterpart of the processor's instruction-fetch read port. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words, one per `$readmemh` line order. It writes each word into sequential instruction-memory addresses and holds the processor in reset until the image is complete. It sits between an external host link (UART/JTAG bridge) and the `imem` write port in `top`.

---
 rtl/imem_loader.sv | 209 ++++++++++++++++++++
 tb/tb_imem_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles big-endian words and writes them to imem while holding the CPU in reset.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte and enable the error output.
module imem_loader #(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DEPTH_LOG2:0]   word_count,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  we,
  output logic [DEPTH_LOG2-1:0] waddr,
  output logic [31:0]           wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [DEPTH_LOG2:0]   MAX_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] IDX_ONE   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE,
    S_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CHECK
`endif
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [23:0]           asm_q, asm_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  in_ready_q, in_ready_d;
  logic                  we_q, we_d;
  logic [DEPTH_LOG2-1:0] waddr_q, waddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
  logic                  error_q, error_d;
`endif

  logic accept;
  logic last_word;

  assign accept    = in_valid & in_ready_q;
  assign last_word = ({1'b0, idx_q} == (count_q - CNT_ONE));

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    asm_d       = asm_q;
    idx_d       = idx_q;
    count_d     = count_q;
    in_ready_d  = 1'b0;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    cpu_reset_d = cpu_reset_q;
    busy_d      = busy_q;
    done_d      = done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
    error_d     = error_q;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start && (word_count != '0)) begin
          state_d     = S_RECV;
          byte_cnt_d  = '0;
          idx_d       = '0;
          count_d     = (word_count > MAX_COUNT) ? MAX_COUNT : word_count;
          in_ready_d  = 1'b1;
          cpu_reset_d = 1'b1;
          busy_d      = 1'b1;
          done_d      = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d      = '0;
          error_d     = 1'b0;
`endif
        end
      end

      S_RECV: begin
        in_ready_d = 1'b1;
        if (accept) begin
          asm_d      = {asm_q[15:0], in_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = csum_q + in_data;
`endif
          // Earlier bytes sit higher in asm_q, so the first byte lands in the MSB.
          if (byte_cnt_q == 2'd3) begin
            state_d    = S_WRITE;
            in_ready_d = 1'b0;
            we_d       = 1'b1;
            waddr_d    = idx_q;
            wdata_d    = {asm_q, in_data};
          end
        end
      end

      S_WRITE: begin
        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d     = S_CHECK;
          in_ready_d  = 1'b1;
`else
          state_d     = S_DONE;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          cpu_reset_d = 1'b0;
`endif
        end else begin
          idx_d      = idx_q + IDX_ONE;
          state_d    = S_RECV;
          in_ready_d = 1'b1;
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        in_ready_d = 1'b1;
        if (accept) begin
          in_ready_d = 1'b0;
          busy_d     = 1'b0;
          if (in_data == csum_q) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            cpu_reset_d = 1'b0;
          end else begin
            state_d     = S_ERR;
            error_d     = 1'b1;
            cpu_reset_d = 1'b1;
          end
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= '0;
      asm_q       <= '0;
      idx_q       <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= '0;
      error_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      asm_q       <= asm_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
      error_q     <= error_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign we        = we_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign error     = error_q;
`else
  assign error     = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: the driver pushes expected writes, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int D     = 6;
  localparam int DEPTH = 1 << D;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int CS_EXTRA = 1;
`else
  localparam int CS_EXTRA = 0;
`endif

  typedef struct {
    logic [D-1:0] addr;
    logic [31:0]  data;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [D:0]   word_count;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic         we;
  logic [D-1:0] waddr;
  logic [31:0]  wdata;
  logic         cpu_reset;
  logic         busy;
  logic         done;
  logic         error;

  imem_loader #(.DEPTH_LOG2(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .word_count(word_count),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_writes = 0;
  int         cyc      = 0;
  bit         alt      = 1'b0;
  exp_t       sb[$];
  logic [7:0] img_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected word.
  always @(negedge clk) begin
    if (reset && we) begin
      exp_t e;
      n_writes++;
      check("in_ready_low_during_we", in_ready, 0);
      check("we_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("waddr", waddr, e.addr);
        check("wdata", wdata, e.data);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  in_ready,  0);
    check({tag, "_we"},        we,        0);
    check({tag, "_waddr"},     waddr,     0);
    check({tag, "_wdata"},     wdata,     0);
    check({tag, "_cpu_reset"}, cpu_reset, 1);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_done"},      done,      0);
    check({tag, "_error"},     error,     0);
  endtask

  // mode 0: valid held high, 1: valid toggles every cycle, 2: random valid.
  task automatic send_byte(input logic [7:0] b, input int mode, input bit pulse);
    bit sent;
    int budget;
    sent   = 1'b0;
    budget = 200;
    in_data = b;
    while (!sent && budget > 0) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       begin in_valid = alt; alt = ~alt; end
        default: in_valid = ($urandom_range(0, 3) != 0);
      endcase
      if (pulse) begin
        start      = 1'b1;
        word_count = 7'd5;
        pulse      = 1'b0;
      end
      sent = in_valid && in_ready;
      @(posedge clk); #1;
      start = 1'b0;
      budget--;
    end
    check("byte_accepted", sent, 1);
  endtask

  // Called at #1 after a rising edge. Uses img_q as the image prefix, filling the rest randomly.
  task automatic run_load(input int wc, input int mode, input int pulse_at,
                          input bit bad_csum, input int exp_edges);
    int   n_words, sum, w0, start_cyc, budget;
    exp_t e;
    n_words = (wc > DEPTH) ? DEPTH : wc;
    while (img_q.size() < 4 * n_words) img_q.push_back(8'($urandom));
    sum = 0;
    w0  = n_writes;
    start      = 1'b1;
    word_count = 7'(wc);
    @(posedge clk); #1;
    start     = 1'b0;
    start_cyc = cyc;
    check("load_in_ready", in_ready, 1);
    check("load_busy", busy, 1);
    check("load_cpu_reset", cpu_reset, 1);
    check("load_done_cleared", done, 0);
    check("load_error_cleared", error, 0);
    for (int i = 0; i < 4 * n_words; i++) begin
      send_byte(img_q[i], mode, i == pulse_at);
      sum += int'(img_q[i]);
      if (i % 4 == 3) begin
        e.addr = D'(i / 4);
        e.data = {img_q[i-3], img_q[i-2], img_q[i-1], img_q[i]};
        sb.push_back(e);
      end
    end
    if (CS_EXTRA != 0) send_byte(bad_csum ? 8'(sum + 1) : 8'(sum), mode, 1'b0);
    in_valid = 1'b0;
    budget = 300;
    while (!done && !error && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check("finish_in_time", budget > 0, 1);
    if (exp_edges > 0) check("done_latency", cyc - start_cyc, exp_edges);
    if (bad_csum) begin
      check("err_error", error, 1);
      check("err_done", done, 0);
      check("err_cpu_reset", cpu_reset, 1);
    end else begin
      check("fin_done", done, 1);
      check("fin_error", error, 0);
      check("fin_cpu_reset", cpu_reset, 0);
    end
    check("fin_busy", busy, 0);
    check("write_count", n_writes - w0, n_words);
    check("scoreboard_drained", sb.size(), 0);
    img_q.delete();
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; word_count = '0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset = 1'b1;
    @(posedge clk); #1;

    // word_count = 0 from IDLE is ignored.
    start = 1'b1; word_count = '0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("zero_in_ready", in_ready, 0);
    check("zero_busy", busy, 0);
    check("zero_cpu_reset", cpu_reset, 1);
    check("zero_done", done, 0);
    check("zero_writes", n_writes, 0);

    // Reference two-word image, stall-free, with latency check.
    img_q = '{8'h20, 8'h02, 8'h00, 8'h05, 8'h20, 8'h03, 8'h00, 8'h0C};
    run_load(2, 0, -1, 1'b0, 10 + CS_EXTRA);

    // Same image with in_valid toggling.
    img_q = '{8'h20, 8'h02, 8'h00, 8'h05, 8'h20, 8'h03, 8'h00, 8'h0C};
    alt = 1'b0;
    run_load(2, 1, -1, 1'b0, 0);

    // Oversized count is clamped to the memory depth.
    run_load(100, 2, -1, 1'b0, 0);

    // start pulsed mid-RECV must not relatch the count.
    run_load(2, 0, 2, 1'b0, 10 + CS_EXTRA);

    // Reset after two bytes of word 0, then a clean one-word load.
    start = 1'b1; word_count = 7'd3;
    @(posedge clk); #1;
    start = 1'b0;
    send_byte(8'hAA, 0, 1'b0);
    send_byte(8'hBB, 0, 1'b0);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    run_load(1, 0, -1, 1'b0, 5 + CS_EXTRA);

`ifdef IMEM_LOADER_CHECKSUM_EN
    run_load(3, 2, -1, 1'b1, 0);
    run_load(2, 2, -1, 1'b0, 0);
`endif

    for (int r = 0; r < 3; r++) run_load($urandom_range(1, 70), 2, -1, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
